lfsr3_checker: RTL and testbench

- Receive-side checker for the 3-bit loadable LFSR sequence generator.
- Samples the generator's parallel output and its load strobe every clock, self-synchronizes to the stream, and predicts each next value.
- Flags mismatches, the stuck all-zero state and each fully verified period.
- Sits at the consumer end of the generator link and feeds status to the lab display and error logic.

---
 rtl/lfsr3_if.sv | 24 ++
 rtl/lfsr3_checker.sv | 123 ++++++++++++
 tb/tb_lfsr3_checker.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr3_if.sv
// Link between the 3-bit LFSR generator side and its receive checker.
// The master drives the sampled stream; the slave returns lock/error status.
interface lfsr3_if #(
    parameter int CNT_W = 8
);
    logic [2:0]       din;
    logic             ld;
    logic             locked;
    logic             stuck;
    logic             err;
    logic             period_ok;
    logic [CNT_W-1:0] err_cnt;
    logic [2:0]       exp_q;

    modport master (
        output din, ld,
        input  locked, stuck, err, period_ok, err_cnt, exp_q
    );

    modport slave (
        input  din, ld,
        output locked, stuck, err, period_ok, err_cnt, exp_q
    );
endinterface

// File: rtl/lfsr3_checker.sv
// Receive-side checker for the 3-bit loadable LFSR: seeds on the stream,
// predicts each next value, and reports mismatches, stuck-at-zero and full periods.
//
// state  | meaning
// -------+-----------------------------------------------------------
// SYNC   | waiting for a non-zero sample to seed the prediction
// LOCKED | comparing every sample against the predicted value
// STUCK  | all-zero sample seen; held until ld or reset
module lfsr3_checker #(
    parameter int CNT_W       = 8,
    parameter int LOSS_THRESH = 3
) (
    input  logic   clk,
    input  logic   rst_n,
    lfsr3_if.slave bus
);
    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        LOCKED = 2'd1,
        STUCK  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       exp_q, exp_d;
    logic [2:0]       miss_q, miss_d;
    logic [2:0]       match_q, match_d;
    logic             err_q, err_d;
    logic             period_ok_q, period_ok_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    function automatic logic [2:0] nxt(input logic [2:0] q);
        return {q[1] ^ q[2], q[0], q[2]};
    endfunction

    always_comb begin
        state_d     = state_q;
        exp_d       = exp_q;
        miss_d      = miss_q;
        match_d     = match_q;
        err_d       = 1'b0;
        period_ok_d = 1'b0;
        err_cnt_d   = err_cnt_q;

        if (bus.ld) begin
            // The loaded value shows up next cycle, so this sample is ignored.
            state_d = SYNC;
            miss_d  = 3'd0;
            match_d = 3'd0;
        end else begin
            case (state_q)
                SYNC: begin
                    if (bus.din != 3'd0) begin
                        exp_d   = nxt(bus.din);
                        state_d = LOCKED;
                    end else begin
                        state_d = STUCK;
                    end
                end
                LOCKED: begin
                    if (bus.din == 3'd0) begin
                        err_d   = 1'b1;
                        state_d = STUCK;
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
                    end else if (bus.din == exp_q) begin
                        exp_d  = nxt(bus.din);
                        miss_d = 3'd0;
                        if (match_q == 3'd6) begin
                            period_ok_d = 1'b1;
                            match_d     = 3'd0;
                        end else begin
                            match_d = match_q + 3'd1;
                        end
                    end else begin
                        // Re-aim on the received value so a single slip costs one error.
                        err_d   = 1'b1;
                        exp_d   = nxt(bus.din);
                        match_d = 3'd0;
                        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
                        if (({1'b0, miss_q} + 4'd1) == 4'(LOSS_THRESH)) begin
                            state_d = SYNC;
                            miss_d  = 3'd0;
                        end else begin
                            miss_d = miss_q + 3'd1;
                        end
                    end
                end
                STUCK: begin
                    state_d = STUCK;
                end
                default: begin
                    state_d = SYNC;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= SYNC;
            exp_q       <= 3'd0;
            miss_q      <= 3'd0;
            match_q     <= 3'd0;
            err_q       <= 1'b0;
            period_ok_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            exp_q       <= exp_d;
            miss_q      <= miss_d;
            match_q     <= match_d;
            err_q       <= err_d;
            period_ok_q <= period_ok_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign bus.locked    = (state_q == LOCKED);
    assign bus.stuck     = (state_q == STUCK);
    assign bus.err       = err_q;
    assign bus.period_ok = period_ok_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.exp_q     = exp_q;
endmodule

// File: tb/tb_lfsr3_checker.sv
// Bench for lfsr3_checker: directed scenarios plus a randomized stream
// checked against an orbit-table reference model, on two parameterizations.
module tb_lfsr3_checker;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_err = 0;
    int   n_chk = 0;

    always #5 clk = ~clk;

    lfsr3_if #(.CNT_W(8)) bus_a ();
    lfsr3_if #(.CNT_W(2)) bus_b ();

    lfsr3_checker #(.CNT_W(8), .LOSS_THRESH(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    lfsr3_checker #(.CNT_W(2), .LOSS_THRESH(7)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    // Reference model: 0 = waiting to seed, 1 = tracking, 2 = stuck.
    int m_mode  [2];
    int m_exp   [2];
    int m_miss  [2];
    int m_match [2];
    int m_cnt   [2];
    int m_err   [2];
    int m_pok   [2];
    int m_thresh[2] = '{3, 7};
    int m_max   [2] = '{255, 3};

    function automatic int orbit_next(input int v);
        int orbit[7] = '{1, 2, 4, 5, 7, 3, 6};
        for (int i = 0; i < 7; i++)
            if (orbit[i] == v) return orbit[(i + 1) % 7];
        return 0;
    endfunction

    task automatic model_step(input int d, input int l, input bit rst);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_mode[k] = 0; m_exp[k] = 0; m_miss[k] = 0; m_match[k] = 0;
                m_cnt[k] = 0; m_err[k] = 0; m_pok[k] = 0;
                continue;
            end
            m_err[k] = 0;
            m_pok[k] = 0;
            if (l != 0) begin
                m_mode[k] = 0; m_miss[k] = 0; m_match[k] = 0;
            end else if (m_mode[k] == 0) begin
                if (d != 0) begin
                    m_exp[k] = orbit_next(d);
                    m_mode[k] = 1;
                end else m_mode[k] = 2;
            end else if (m_mode[k] == 1) begin
                if (d == 0) begin
                    m_err[k] = 1;
                    m_cnt[k] = (m_cnt[k] + 1 > m_max[k]) ? m_max[k] : m_cnt[k] + 1;
                    m_mode[k] = 2;
                end else if (d == m_exp[k]) begin
                    m_exp[k] = orbit_next(d);
                    m_miss[k] = 0;
                    m_match[k]++;
                    if (m_match[k] == 7) begin
                        m_pok[k] = 1;
                        m_match[k] = 0;
                    end
                end else begin
                    m_err[k] = 1;
                    m_cnt[k] = (m_cnt[k] + 1 > m_max[k]) ? m_max[k] : m_cnt[k] + 1;
                    m_exp[k] = orbit_next(d);
                    m_match[k] = 0;
                    m_miss[k]++;
                    if (m_miss[k] == m_thresh[k]) begin
                        m_mode[k] = 0;
                        m_miss[k] = 0;
                    end
                end
            end
        end
    endtask

    function automatic logic [14:0] model_vec(input int k);
        logic [7:0] c;
        logic [2:0] e;
        c = 8'(m_cnt[k]);
        e = 3'(m_exp[k]);
        return {m_mode[k] == 1, m_mode[k] == 2, m_err[k] != 0, m_pok[k] != 0, c, e};
    endfunction

    task automatic cyc(input logic [2:0] d, input logic l);
        bus_a.din = d; bus_a.ld = l;
        bus_b.din = d; bus_b.ld = l;
        @(posedge clk);
        #1;
        model_step(int'(d), int'(l), !rst_n);
    endtask

    task automatic do_reset(input logic [2:0] d);
        rst_n = 1'b0;
        cyc(d, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        logic [14:0] obs;
        cyc(3'b001, 1'b0);
        cyc(3'b011, 1'b0);
        do_reset(3'b101);
        obs = {bus_a.locked, bus_a.stuck, bus_a.err, bus_a.period_ok, bus_a.err_cnt, bus_a.exp_q};
        n_chk++;
        if (obs !== 15'd0) begin
            n_err++; $display("FAIL reset_a got=%h want=0", obs);
        end
        obs = {bus_b.locked, bus_b.stuck, bus_b.err, bus_b.period_ok, 6'd0, bus_b.err_cnt, bus_b.exp_q};
        n_chk++;
        if (obs !== 15'd0) begin
            n_err++; $display("FAIL reset_b got=%h want=0", obs);
        end
    endtask

    task automatic test_clean_stream;
        logic [2:0] seq[8] = '{3'b001, 3'b010, 3'b100, 3'b101, 3'b111, 3'b011, 3'b110, 3'b001};
        int errs_seen = 0;
        int pok_seen = 0;
        do_reset(3'b000);
        for (int i = 0; i < 8; i++) begin
            cyc(seq[i], 1'b0);
            errs_seen += int'(bus_a.err);
            if (i < 7) pok_seen += int'(bus_a.period_ok);
            n_chk++;
            if (bus_a.locked !== 1'b1) begin
                n_err++; $display("FAIL clean_locked i=%0d got=%b want=1", i, bus_a.locked);
            end
        end
        n_chk++;
        if (bus_a.period_ok !== 1'b1 || pok_seen != 0) begin
            n_err++; $display("FAIL clean_period_ok got=%b early=%0d want=1 early=0", bus_a.period_ok, pok_seen);
        end
        n_chk++;
        if (errs_seen != 0 || bus_a.err_cnt !== 8'd0) begin
            n_err++; $display("FAIL clean_err got err=%0d cnt=%0d want 0 0", errs_seen, bus_a.err_cnt);
        end
        cyc(3'b010, 1'b0);
        n_chk++;
        if (bus_a.period_ok !== 1'b0) begin
            n_err++; $display("FAIL clean_pok_width got=%b want=0", bus_a.period_ok);
        end
    endtask

    task automatic test_zero_injection;
        do_reset(3'b000);
        cyc(3'b001, 1'b0);
        cyc(3'b010, 1'b0);
        cyc(3'b000, 1'b0);
        n_chk++;
        if ({bus_a.err, bus_a.err_cnt, bus_a.stuck, bus_a.locked} !== {1'b1, 8'd1, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL zero_inject got err=%b cnt=%0d stuck=%b locked=%b want 1 1 1 0",
                              bus_a.err, bus_a.err_cnt, bus_a.stuck, bus_a.locked);
        end
        for (int i = 0; i < 3; i++) cyc(3'b001, 1'b0);
        n_chk++;
        if ({bus_a.stuck, bus_a.err, bus_a.err_cnt} !== {1'b1, 1'b0, 8'd1}) begin
            n_err++; $display("FAIL zero_hold got stuck=%b err=%b cnt=%0d want 1 0 1",
                              bus_a.stuck, bus_a.err, bus_a.err_cnt);
        end
        cyc(3'b011, 1'b1);
        n_chk++;
        if ({bus_a.stuck, bus_a.locked, bus_a.err} !== 3'b000) begin
            n_err++; $display("FAIL zero_ld got stuck=%b locked=%b err=%b want 0 0 0",
                              bus_a.stuck, bus_a.locked, bus_a.err);
        end
        cyc(3'b101, 1'b0);
        n_chk++;
        if ({bus_a.locked, bus_a.exp_q} !== {1'b1, 3'b111}) begin
            n_err++; $display("FAIL zero_relock got locked=%b exp=%b want 1 111", bus_a.locked, bus_a.exp_q);
        end
    endtask

    task automatic test_loss_of_lock;
        logic [2:0] want_locked = 3'b110;
        do_reset(3'b000);
        cyc(3'b001, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(3'b111, 1'b0);
            n_chk++;
            if ({bus_a.err, bus_a.err_cnt, bus_a.locked} !== {1'b1, 8'(i + 1), want_locked[2-i]}) begin
                n_err++; $display("FAIL loss_miss%0d got err=%b cnt=%0d locked=%b want 1 %0d %b",
                                  i, bus_a.err, bus_a.err_cnt, bus_a.locked, i + 1, want_locked[2-i]);
            end
        end
        cyc(3'b011, 1'b0);
        n_chk++;
        if ({bus_a.locked, bus_a.err, bus_a.exp_q} !== {1'b1, 1'b0, 3'b110}) begin
            n_err++; $display("FAIL loss_relock got locked=%b err=%b exp=%b want 1 0 110",
                              bus_a.locked, bus_a.err, bus_a.exp_q);
        end
        cyc(3'b110, 1'b0);
        n_chk++;
        if ({bus_a.err, bus_a.err_cnt, bus_a.exp_q} !== {1'b0, 8'd3, 3'b001}) begin
            n_err++; $display("FAIL loss_match got err=%b cnt=%0d exp=%b want 0 3 001",
                              bus_a.err, bus_a.err_cnt, bus_a.exp_q);
        end
    endtask

    task automatic test_load_mid_run;
        do_reset(3'b000);
        cyc(3'b001, 1'b0);
        cyc(3'b010, 1'b0);
        cyc(3'b111, 1'b1);
        n_chk++;
        if ({bus_a.err, bus_a.locked} !== 2'b00) begin
            n_err++; $display("FAIL ld_wins got err=%b locked=%b want 0 0", bus_a.err, bus_a.locked);
        end
        cyc(3'b101, 1'b0);
        n_chk++;
        if ({bus_a.locked, bus_a.err, bus_a.exp_q} !== {1'b1, 1'b0, 3'b111}) begin
            n_err++; $display("FAIL ld_relock got locked=%b err=%b exp=%b want 1 0 111",
                              bus_a.locked, bus_a.err, bus_a.exp_q);
        end
        cyc(3'b111, 1'b0);
        n_chk++;
        if ({bus_a.err, bus_a.err_cnt} !== {1'b0, 8'd0}) begin
            n_err++; $display("FAIL ld_match got err=%b cnt=%0d want 0 0", bus_a.err, bus_a.err_cnt);
        end
    endtask

    task automatic test_saturation;
        int want[6] = '{1, 2, 3, 3, 3, 3};
        do_reset(3'b000);
        cyc(3'b001, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cyc(3'b001, 1'b0);
            n_chk++;
            if ({bus_b.err_cnt, bus_b.locked, bus_b.err} !== {2'(want[i]), 1'b1, 1'b1}) begin
                n_err++; $display("FAIL sat_%0d got cnt=%0d locked=%b err=%b want %0d 1 1",
                                  i, bus_b.err_cnt, bus_b.locked, bus_b.err, want[i]);
            end
        end
    endtask

    task automatic test_reset_mid;
        do_reset(3'b000);
        cyc(3'b001, 1'b0);
        cyc(3'b111, 1'b0);
        cyc(3'b111, 1'b0);
        n_chk++;
        if ({bus_a.locked, bus_a.err_cnt} !== {1'b1, 8'd2}) begin
            n_err++; $display("FAIL rstmid_pre got locked=%b cnt=%0d want 1 2", bus_a.locked, bus_a.err_cnt);
        end
        do_reset(3'b110);
        n_chk++;
        if ({bus_a.locked, bus_a.stuck, bus_a.err, bus_a.period_ok, bus_a.err_cnt, bus_a.exp_q} !== 15'd0) begin
            n_err++; $display("FAIL rstmid_clear got locked=%b stuck=%b err=%b cnt=%0d exp=%b want all 0",
                              bus_a.locked, bus_a.stuck, bus_a.err, bus_a.err_cnt, bus_a.exp_q);
        end
        cyc(3'b010, 1'b0);
        n_chk++;
        if ({bus_a.locked, bus_a.exp_q, bus_a.err} !== {1'b1, 3'b100, 1'b0}) begin
            n_err++; $display("FAIL rstmid_seed got locked=%b exp=%b err=%b want 1 100 0",
                              bus_a.locked, bus_a.exp_q, bus_a.err);
        end
    endtask

    task automatic test_random_stream;
        logic [14:0] obs;
        logic [2:0]  d;
        logic        l;
        int          r;
        do_reset(3'b000);
        for (int n = 0; n < 1500; n++) begin
            r = int'($urandom_range(0, 15));
            if (r < 11 && m_exp[0] != 0) d = 3'(m_exp[0]);
            else if (r < 11)             d = 3'($urandom_range(1, 7));
            else                         d = 3'($urandom_range(0, 7));
            l = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 299) == 0) do_reset(d);
            else cyc(d, l);
            obs = {bus_a.locked, bus_a.stuck, bus_a.err, bus_a.period_ok, bus_a.err_cnt, bus_a.exp_q};
            n_chk++;
            if (obs !== model_vec(0)) begin
                n_err++; $display("FAIL rand_a n=%0d got=%h want=%h", n, obs, model_vec(0));
            end
            obs = {bus_b.locked, bus_b.stuck, bus_b.err, bus_b.period_ok, 6'd0, bus_b.err_cnt, bus_b.exp_q};
            n_chk++;
            if (obs !== model_vec(1)) begin
                n_err++; $display("FAIL rand_b n=%0d got=%h want=%h", n, obs, model_vec(1));
            end
        end
    endtask

    initial begin
        bus_a.din = 3'd0; bus_a.ld = 1'b0;
        bus_b.din = 3'd0; bus_b.ld = 1'b0;
        model_step(0, 0, 1'b1);
        test_reset();
        test_clean_stream();
        test_zero_injection();
        test_loss_of_lock();
        test_load_mid_run();
        test_saturation();
        test_reset_mid();
        test_random_stream();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
